// File: rtl/sub_serial_if.sv
// Start/result bus for the bit-serial subtractor: en/a/b in, out/borrow_out/done back.
// The ovf signal exists only when SUB_SERIAL_OVF_EN is defined.
interface sub_serial_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             borrow_out;
  logic             done;
`ifdef SUB_SERIAL_OVF_EN
  logic             ovf;

  modport master (
    output en, a, b,
    input  out, borrow_out, done, ovf
  );

  modport slave (
    input  en, a, b,
    output out, borrow_out, done, ovf
  );
`else
  modport master (
    output en, a, b,
    input  out, borrow_out, done
  );

  modport slave (
    input  en, a, b,
    output out, borrow_out, done
  );
`endif
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor (out = a - b, LSB first, one bit per clock), result held until re-armed.
// Optional signed overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  sub_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic             borrow_q;
  logic             borrowOut_q;
  logic [CW-1:0]    count_q;
  logic             diff_d;
  logic             borrow_d;
`ifdef SUB_SERIAL_OVF_EN
  logic             ovf_q;
`endif

  // Full-subtractor cell on the current LSBs
  assign diff_d   = a_q[0] ^ b_q[0] ^ borrow_q;
  assign borrow_d = (~a_q[0] & b_q[0]) | (~a_q[0] & borrow_q) | (b_q[0] & borrow_q);

  assign bus.out        = out_q;
  assign bus.borrow_out = borrowOut_q;
  assign bus.done       = (state_q == DONE);
`ifdef SUB_SERIAL_OVF_EN
  assign bus.ovf        = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      borrow_q    <= 1'b0;
      borrowOut_q <= 1'b0;
      count_q     <= '0;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            out_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            state_q  <= SUB;
          end
        end
        SUB: begin
          out_q    <= {diff_d, out_q[WIDTH-1:1]};
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= borrow_d;
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            borrowOut_q <= borrow_d;
`ifdef SUB_SERIAL_OVF_EN
            // On the MSB cycle borrow_q is the borrow into the sign bit
            ovf_q       <= borrow_q ^ borrow_d;
`endif
          end
        end
        DONE: begin
          if (bus.en) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: directed vectors push expected results, a monitor checks each done rise.
// Overflow checks are compiled in when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial;
  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  sub_serial_if #(.WIDTH(WIDTH)) bus ();

  sub_serial #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest queued expectation
  initial begin
    logic prevDone;
    exp_t e;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && prevDone !== 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'(bus.out), 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_out", 32'(bus.out), 32'(e.out));
          checkOutput("sb_borrow", 32'(bus.borrow_out), 32'(e.borrow));
`ifdef SUB_SERIAL_OVF_EN
          checkOutput("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        end
      end
      prevDone = bus.done;
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] eo, input logic eb, input logic eov,
                               input bit pushExp, input bit keepEn);
    exp_t e;
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = a;
    bus.b  = b;
    if (pushExp) begin
      e.out    = eo;
      e.borrow = eb;
      e.ovf    = eov;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keepEn) bus.en = 1'b0;
  endtask

  task automatic waitDone(input string name, output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 4 * WIDTH) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput(name, 32'(bus.done), 32'h1);
  endtask

  task automatic rearm();
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    checkOutput("rearm_done_low", 32'(bus.done), 32'h0);
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eo, input logic eb, input logic eov);
    int cycles;
    applyStimulus(a, b, eo, eb, eov, 1'b1, 1'b0);
    bus.a = ~a;
    bus.b = ~b;
    waitDone("done_timeout", cycles);
    checkOutput("latency", 32'(cycles), 32'(WIDTH));
    repeat (3) @(negedge clk);
    checkOutput("held_done", 32'(bus.done), 32'h1);
    checkOutput("held_out", 32'(bus.out), 32'(eo));
    checkOutput("held_borrow", 32'(bus.borrow_out), 32'(eb));
    rearm();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cycles;
    bus.en = 1'b0;
    bus.a  = '0;
    bus.b  = '0;

    #12;
    checkOutput("reset_out", 32'(bus.out), 32'h0);
    checkOutput("reset_borrow", 32'(bus.borrow_out), 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'h0);
`ifdef SUB_SERIAL_OVF_EN
    checkOutput("reset_ovf", 32'(bus.ovf), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    runOp(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    runOp(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    runOp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    runOp(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    runOp(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    runOp(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    runOp(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    // Back-to-back ops with en held high; operands scrambled while subtracting
    applyStimulus(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    waitDone("b2b_done1_timeout", cycles);
    checkOutput("b2b_latency1", 32'(cycles), 32'(WIDTH));
    checkOutput("b2b_out1", 32'(bus.out), 32'h37);
    bus.a = 8'h01;
    bus.b = 8'h02;
    expQ.push_back('{out: 8'hFF, borrow: 1'b1, ovf: 1'b0});
    @(posedge clk);
    #1;
    checkOutput("b2b_idle_done_low", 32'(bus.done), 32'h0);
    @(posedge clk);
    #1;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    waitDone("b2b_done2_timeout", cycles);
    checkOutput("b2b_latency2", 32'(cycles), 32'(WIDTH));
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2b_held_out", 32'(bus.out), 32'hFF);
    checkOutput("b2b_held_borrow", 32'(bus.borrow_out), 32'h1);
    rearm();

    // Reset in the middle of an operation
    applyStimulus(8'h5A, 8'h23, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_out", 32'(bus.out), 32'h0);
    checkOutput("abort_done", 32'(bus.done), 32'h0);
    checkOutput("abort_borrow", 32'(bus.borrow_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    runOp(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
